// File: rtl/quad_velocity_estimator.sv
// -----------------------------------------------------------------------------
// quad_velocity_estimator
//
// Purpose: periodically samples a signed quadrature encoder count and reports
// the change in count per sample window (velocity). The window length, enable
// and a clear command are programmable through a small register interface.
//
// Optional build macro QUAD_VEL_IIR_EN: when defined, every new delta is fed
// through a first-order IIR smoother (filt += (delta - filt) >>> 2). Address 0
// then returns the filtered value instead of the raw delta.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active-high
//   position     - 32-bit signed encoder count (same clock domain)
//   address      - register select (0 velocity, 1 window, 2 sample_count,
//                  3 control {bit1 clear, bit0 enable})
//   read         - read strobe; readdata updates on the following edge
//   readdata     - registered read data, holds when read is low
//   write        - write strobe
//   writedata    - write data
//   sample_valid - one-cycle pulse aligned with each velocity update
// -----------------------------------------------------------------------------
module quad_velocity_estimator #(
  parameter int CLOCK_FREQ_HZ  = 50_000_000,
  parameter int DEFAULT_WINDOW = CLOCK_FREQ_HZ / 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] position,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        sample_valid
);

  // A window of zero cycles is meaningless; clamp to one.
  localparam logic [31:0] RESET_WINDOW =
    (DEFAULT_WINDOW < 1) ? 32'd1 : 32'(DEFAULT_WINDOW);

  logic [31:0] window_q,   window_d;
  logic        enable_q,   enable_d;
  logic [31:0] counter_q,  counter_d;
  logic [31:0] prev_q,     prev_d;
  // Value returned at address 0: raw delta, or filter state when the IIR is on.
  logic [31:0] vel_q,      vel_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] readdata_q, readdata_d;
  logic        sample_valid_q;

  logic        wr_window;
  logic        wr_ctrl;
  logic        clear;
  logic        enable_rise;
  logic        restart;
  logic        terminal;
  logic        do_sample;
  logic [31:0] delta;
  logic [31:0] rd_mux;

  assign wr_window   = write && (address == 2'd1);
  assign wr_ctrl     = write && (address == 2'd3);
  assign clear       = wr_ctrl && writedata[1];
  assign enable_d    = wr_ctrl ? writedata[0] : enable_q;
  assign enable_rise = enable_d && !enable_q;

  // Any of these discards the partial window and re-bases prev_position.
  // They take priority over a coincident terminal count.
  assign restart   = wr_window || clear || enable_rise;
  assign terminal  = (counter_q == (window_q - 32'd1));
  // Disabling in the terminal cycle also suppresses the sample.
  assign do_sample = enable_q && enable_d && !restart && terminal;

  // Modulo-2^32 subtraction is inherently correct across counter wrap.
  assign delta = position - prev_q;

  assign window_d = wr_window ? ((writedata == 32'd0) ? 32'd1 : writedata)
                              : window_q;

  always_comb begin
    counter_d = counter_q + 32'd1;
    if (restart || !enable_d || terminal) begin
      counter_d = '0;
    end
  end

  assign prev_d  = (restart || do_sample) ? position : prev_q;
  assign count_d = clear ? '0 : (do_sample ? count_q + 32'd1 : count_q);

`ifdef QUAD_VEL_IIR_EN
  // Difference at 33 bits so it cannot overflow; arithmetic shift, then the
  // step is truncated back to 32 bits before the modulo add.
  logic [32:0] filt_diff;
  logic [31:0] filt_step;

  assign filt_diff = {delta[31], delta} - {vel_q[31], vel_q};
  assign filt_step = 32'($signed(filt_diff) >>> 2);
  assign vel_d     = clear ? '0 : (do_sample ? vel_q + filt_step : vel_q);
`else
  assign vel_d     = clear ? '0 : (do_sample ? delta : vel_q);
`endif

  // Read mux sees pre-write register values, so a same-cycle read/write of
  // one address returns the old contents.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = vel_q;
      2'd1:    rd_mux = window_q;
      2'd2:    rd_mux = count_q;
      default: rd_mux = {30'b0, 1'b0, enable_q};
    endcase
  end

  assign readdata_d = read ? rd_mux : readdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      window_q       <= RESET_WINDOW;
      enable_q       <= 1'b1;
      counter_q      <= '0;
      prev_q         <= position;
      vel_q          <= '0;
      count_q        <= '0;
      readdata_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      window_q       <= window_d;
      enable_q       <= enable_d;
      counter_q      <= counter_d;
      prev_q         <= prev_d;
      vel_q          <= vel_d;
      count_q        <= count_d;
      readdata_q     <= readdata_d;
      sample_valid_q <= do_sample;
    end
  end

  assign readdata     = readdata_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: doc/quad_velocity_estimator.md
QUAD_VELOCITY_ESTIMATOR -- requirements
Module: quad_velocity_estimator

Interface
REQ-001 Parameter CLOCK_FREQ_HZ, default 50_000_000, input clock frequency, informational only; used to derive DEFAULT_WINDOW.
REQ-002 Parameter DEFAULT_WINDOW, default CLOCK_FREQ_HZ/100, sample window length in clk cycles after reset.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 position  input  32  signed encoder count from the upstream quadrature decoder, same clock domain.
REQ-006 address  input  2  register select.
REQ-007 read  input  1  read strobe.
REQ-008 readdata  output  32  read data, registered.
REQ-009 write  input  1  write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 sample_valid  output  1  one-cycle pulse when a new velocity value is stored.

Function
REQ-012 Register map: 0 = velocity (RO), 1 = window (RW), 2 = sample_count (RO), 3 = control (RW: bit0 enable, bit1 clear, self-clearing; read returns {30'b0, 1'b0, enable}).
REQ-013 readdata shall update on the cycle after read is high; it holds its value when read is low.
REQ-014 Window counter counts 0..window-1 while enable=1; at terminal count it returns to 0 and a sample is taken.
REQ-015 Sample: delta = position - prev_position, 32-bit two's-complement subtraction with modulo 2^32 wrap, correct across counter wrap; prev_position <= position; velocity <= delta; sample_count <= sample_count + 1, wrapping at 2^32; sample_valid pulses in the same cycle as the register update.
REQ-016 A write to window stores max(writedata, 1). The window counter restarts at 0 and prev_position reloads from position; the partial window is discarded.
REQ-017 A write to window in the terminal-count cycle shall win; no sample is taken in that cycle.
REQ-018 enable=0: window counter held at 0, no samples, velocity and sample_count hold.
REQ-019 Enable transition 0->1: prev_position reloads from position and the counter starts at 0.
REQ-020 Clear bit written 1: velocity, sample_count and filter state set to 0, counter restarts at 0, prev_position reloads; clear overrides a coincident sample.
REQ-021 A write to a read-only address shall be ignored.
REQ-022 Read and write in the same cycle to the same address: readdata returns the pre-write value.

Reset
REQ-023 On reset: velocity=0, sample_count=0, window=DEFAULT_WINDOW, enable=1, counter=0, prev_position<=position, readdata=0, sample_valid=0, filter state=0.
REQ-024 Reset asserted mid-window shall discard the partial window; the first sample after reset lands DEFAULT_WINDOW cycles after reset deasserts.

Configuration
REQ-025 Macro QUAD_VEL_IIR_EN defined: at each sample, filt <= filt + ((delta - filt) >>> 2). The difference is computed at 33 bits with arithmetic shift, and the result is truncated to 32 bits. Address 0 returns filt.
REQ-026 QUAD_VEL_IIR_EN undefined: no filter logic; address 0 returns the raw delta.

Verification
REQ-027 Reset, window=10, position increments +3 every cycle -> sample_valid every 10 cycles, velocity reads 30, sample_count increments by 1 per sample.
REQ-028 position steps 0x7FFFFFF0 -> 0x80000010 within one window -> velocity reads 0x00000020 (wrap-correct); a reverse step gives 0xFFFFFFE0.
REQ-029 Write window=0 -> window reads 1, sample_valid every cycle; write window=5 in the terminal-count cycle -> no sample that cycle, next sample 5 cycles later.
REQ-030 Write control=0 for 50 cycles while position moves, then control=1 -> no samples while disabled; first sample after re-enable reflects only motion after re-enable.
REQ-031 Write control=3 with velocity=30 -> velocity and sample_count read 0, enable stays 1.
REQ-032 QUAD_VEL_IIR_EN defined, constant delta 40 from filt=0 -> address 0 reads 10, 17, 22, 26 over successive samples.
